// File: rtl/miriscv_decode_stage_pkg.sv
// Shared constants for the miriscv decode stage: ALU operator codes, RV32I opcodes,
// operand-select encodings and the decoded bundle carried into execute.
package miriscv_decode_stage_pkg;

    localparam int ALU_OP_WIDTH = 6;

    localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD = 6'b011000;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB = 6'b011001;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_XOR = 6'b101111;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OR  = 6'b101110;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_AND = 6'b010101;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SRA = 6'b100100;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SRL = 6'b100101;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SLL = 6'b100111;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_LTS = 6'b000000;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_LTU = 6'b000001;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_GES = 6'b001010;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_GEU = 6'b001011;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_EQ  = 6'b001100;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_NE  = 6'b001101;

    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [1:0] OP_A_RS1     = 2'd0;
    localparam logic [1:0] OP_A_CURR_PC = 2'd1;
    localparam logic [1:0] OP_A_ZERO    = 2'd2;

    localparam logic [2:0] OP_B_RS2     = 3'd0;
    localparam logic [2:0] OP_B_IMM     = 3'd1;
    localparam logic [2:0] OP_B_INCR    = 3'd2;

    typedef struct packed {
        logic [ALU_OP_WIDTH-1:0] alu_op;
        logic [1:0]              a_sel;
        logic [2:0]              b_sel;
        logic [31:0]             imm;
        logic                    gpr_we;
        logic                    mem_req;
        logic                    mem_we;
        logic [2:0]              mem_size;
        logic                    branch;
        logic                    jal;
        logic                    jalr;
        logic                    illegal;
    } decode_bundle_t;

    // Quiet bundle: everything zero except the ALU defaulting to an add.
    function automatic decode_bundle_t reset_bundle();
        decode_bundle_t b;
        b        = '0;
        b.alu_op = ALU_ADD;
        return b;
    endfunction

endpackage

// File: rtl/miriscv_decode_stage_decoder.sv
// Purely combinational RV32I decoder: one instruction word in, one control bundle out.
module miriscv_decoder
    import miriscv_decode_stage_pkg::*;
(
    input  logic [31:0]    instr,
    output decode_bundle_t bundle
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;
    logic        ill;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    always_comb begin
        ill    = 1'b0;
        bundle = reset_bundle();
        if (instr[1:0] != 2'b11) begin
            ill = 1'b1;
        end else begin
            case (opcode)
                OPC_OP: begin
                    bundle.gpr_we = 1'b1;
                    if (funct7 == 7'b0000000) begin
                        case (funct3)
                            3'b000:  bundle.alu_op = ALU_ADD;
                            3'b001:  bundle.alu_op = ALU_SLL;
                            3'b010:  bundle.alu_op = ALU_LTS;
                            3'b011:  bundle.alu_op = ALU_LTU;
                            3'b100:  bundle.alu_op = ALU_XOR;
                            3'b101:  bundle.alu_op = ALU_SRL;
                            3'b110:  bundle.alu_op = ALU_OR;
                            default: bundle.alu_op = ALU_AND;
                        endcase
                    end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                        bundle.alu_op = ALU_SUB;
                    end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
                        bundle.alu_op = ALU_SRA;
                    end else begin
                        ill = 1'b1;
                    end
                end
                OPC_OP_IMM: begin
                    bundle.b_sel  = OP_B_IMM;
                    bundle.imm    = imm_i;
                    bundle.gpr_we = 1'b1;
                    case (funct3)
                        3'b000: bundle.alu_op = ALU_ADD;
                        3'b010: bundle.alu_op = ALU_LTS;
                        3'b011: bundle.alu_op = ALU_LTU;
                        3'b100: bundle.alu_op = ALU_XOR;
                        3'b110: bundle.alu_op = ALU_OR;
                        3'b111: bundle.alu_op = ALU_AND;
                        3'b001: begin
                            if (funct7 == 7'b0000000) bundle.alu_op = ALU_SLL;
                            else                      ill = 1'b1;
                        end
                        default: begin
                            if (funct7 == 7'b0000000)      bundle.alu_op = ALU_SRL;
                            else if (funct7 == 7'b0100000) bundle.alu_op = ALU_SRA;
                            else                           ill = 1'b1;
                        end
                    endcase
                end
                OPC_LUI: begin
                    bundle.a_sel  = OP_A_ZERO;
                    bundle.b_sel  = OP_B_IMM;
                    bundle.imm    = imm_u;
                    bundle.gpr_we = 1'b1;
                end
                OPC_AUIPC: begin
                    bundle.a_sel  = OP_A_CURR_PC;
                    bundle.b_sel  = OP_B_IMM;
                    bundle.imm    = imm_u;
                    bundle.gpr_we = 1'b1;
                end
                OPC_JAL: begin
                    bundle.a_sel  = OP_A_CURR_PC;
                    bundle.b_sel  = OP_B_INCR;
                    bundle.imm    = imm_j;
                    bundle.jal    = 1'b1;
                    bundle.gpr_we = 1'b1;
                end
                OPC_JALR: begin
                    bundle.a_sel  = OP_A_CURR_PC;
                    bundle.b_sel  = OP_B_INCR;
                    bundle.imm    = imm_i;
                    bundle.jalr   = 1'b1;
                    bundle.gpr_we = 1'b1;
                    if (funct3 != 3'b000) ill = 1'b1;
                end
                OPC_BRANCH: begin
                    bundle.imm    = imm_b;
                    bundle.branch = 1'b1;
                    case (funct3)
                        3'b000:  bundle.alu_op = ALU_EQ;
                        3'b001:  bundle.alu_op = ALU_NE;
                        3'b100:  bundle.alu_op = ALU_LTS;
                        3'b101:  bundle.alu_op = ALU_GES;
                        3'b110:  bundle.alu_op = ALU_LTU;
                        3'b111:  bundle.alu_op = ALU_GEU;
                        default: ill = 1'b1;
                    endcase
                end
                OPC_LOAD: begin
                    bundle.b_sel    = OP_B_IMM;
                    bundle.imm      = imm_i;
                    bundle.mem_req  = 1'b1;
                    bundle.mem_size = funct3;
                    bundle.gpr_we   = 1'b1;
                    if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111) ill = 1'b1;
                end
                OPC_STORE: begin
                    bundle.b_sel    = OP_B_IMM;
                    bundle.imm      = imm_s;
                    bundle.mem_req  = 1'b1;
                    bundle.mem_we   = 1'b1;
                    bundle.mem_size = funct3;
                    if (funct3[2] || funct3 == 3'b011) ill = 1'b1;
                end
                OPC_MISC_MEM: begin
                    // FENCE has nothing to order in this core: pass it through as a NOP.
                end
                OPC_SYSTEM: ill = 1'b1;
                default:    ill = 1'b1;
            endcase
        end
        if (ill) begin
            bundle         = reset_bundle();
            bundle.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/miriscv_decode_stage.sv
// Registered decode stage: one pipeline register around miriscv_decoder with
// valid/ready handshakes toward fetch and execute, plus flush.
module miriscv_decode_stage
    import miriscv_decode_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                    clk_i,
    input  logic                    arstn_i,
    input  logic                    flush_i,
    input  logic                    instr_valid_i,
    output logic                    instr_ready_o,
    input  logic [31:0]             instr_i,
    input  logic [31:0]             pc_i,
    output logic                    ex_valid_o,
    input  logic                    ex_ready_i,
    output logic [31:0]             pc_o,
    output logic [ALU_OP_WIDTH-1:0] alu_op_o,
    output logic [1:0]              a_sel_o,
    output logic [2:0]              b_sel_o,
    output logic [31:0]             imm_o,
    output logic [4:0]              rs1_addr_o,
    output logic [4:0]              rs2_addr_o,
    output logic [4:0]              rd_addr_o,
    output logic                    gpr_we_o,
    output logic                    mem_req_o,
    output logic                    mem_we_o,
    output logic [2:0]              mem_size_o,
    output logic                    branch_o,
    output logic                    jal_o,
    output logic                    jalr_o,
    output logic                    illegal_instr_o
);

    decode_bundle_t dec;
    decode_bundle_t bundle_q;
    logic           load;

    miriscv_decoder u_decoder (
        .instr  (instr_i),
        .bundle (dec)
    );

    // Handshake: a transfer happens on a rising edge where valid && ready; the
    // producer holds its payload stable while valid is high and ready is low.
    // The register is free when empty or when execute drains it this cycle.
    assign instr_ready_o = !ex_valid_o || ex_ready_i;
    assign load          = instr_valid_i && instr_ready_o && !flush_i;

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            ex_valid_o <= 1'b0;
            pc_o       <= RESET_PC;
            bundle_q   <= reset_bundle();
            rs1_addr_o <= 5'd0;
            rs2_addr_o <= 5'd0;
            rd_addr_o  <= 5'd0;
        end else if (flush_i) begin
            ex_valid_o <= 1'b0;
        end else if (load) begin
            ex_valid_o <= 1'b1;
            pc_o       <= pc_i;
            bundle_q   <= dec;
            rs1_addr_o <= instr_i[19:15];
            rs2_addr_o <= instr_i[24:20];
            rd_addr_o  <= instr_i[11:7];
        end else if (ex_ready_i) begin
            ex_valid_o <= 1'b0;
        end
    end

    assign alu_op_o        = bundle_q.alu_op;
    assign a_sel_o         = bundle_q.a_sel;
    assign b_sel_o         = bundle_q.b_sel;
    assign imm_o           = bundle_q.imm;
    assign gpr_we_o        = bundle_q.gpr_we;
    assign mem_req_o       = bundle_q.mem_req;
    assign mem_we_o        = bundle_q.mem_we;
    assign mem_size_o      = bundle_q.mem_size;
    assign branch_o        = bundle_q.branch;
    assign jal_o           = bundle_q.jal;
    assign jalr_o          = bundle_q.jalr;
    assign illegal_instr_o = bundle_q.illegal;

endmodule

// File: tb/tb_miriscv_decode_stage.sv
// Self-checking bench for miriscv_decode_stage: hand-decoded instruction table,
// expected-bundle queue compared whenever execute consumes a bundle.
module tb_miriscv_decode_stage;

    localparam int          W      = 100;
    localparam int          BW     = W - 32;
    localparam logic [31:0] RST_PC = 32'h0000_0200;

    localparam logic [5:0] E_ADD = 6'b011000;
    localparam logic [5:0] E_SUB = 6'b011001;
    localparam logic [5:0] E_EQ  = 6'b001100;
    localparam logic [5:0] E_LTS = 6'b000000;
    localparam logic [5:0] E_SRA = 6'b100100;

    logic        clk;
    logic        arstn_i;
    logic        flush_i;
    logic        instr_valid_i;
    logic        instr_ready_o;
    logic [31:0] instr_i;
    logic [31:0] pc_i;
    logic        ex_valid_o;
    logic        ex_ready_i;
    logic [31:0] pc_o;
    logic [5:0]  alu_op_o;
    logic [1:0]  a_sel_o;
    logic [2:0]  b_sel_o;
    logic [31:0] imm_o;
    logic [4:0]  rs1_addr_o;
    logic [4:0]  rs2_addr_o;
    logic [4:0]  rd_addr_o;
    logic        gpr_we_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [2:0]  mem_size_o;
    logic        branch_o;
    logic        jal_o;
    logic        jalr_o;
    logic        illegal_instr_o;

    int checks;
    int errors;
    int cyc;
    logic [31:0] next_pc;

    logic [W-1:0]  exp_q[$];
    logic [31:0]   tbl_instr[16];
    logic [BW-1:0] tbl_body[16];
    logic [W-1:0]  act;

    miriscv_decode_stage #(.RESET_PC(RST_PC)) dut (
        .clk_i           (clk),
        .arstn_i         (arstn_i),
        .flush_i         (flush_i),
        .instr_valid_i   (instr_valid_i),
        .instr_ready_o   (instr_ready_o),
        .instr_i         (instr_i),
        .pc_i            (pc_i),
        .ex_valid_o      (ex_valid_o),
        .ex_ready_i      (ex_ready_i),
        .pc_o            (pc_o),
        .alu_op_o        (alu_op_o),
        .a_sel_o         (a_sel_o),
        .b_sel_o         (b_sel_o),
        .imm_o           (imm_o),
        .rs1_addr_o      (rs1_addr_o),
        .rs2_addr_o      (rs2_addr_o),
        .rd_addr_o       (rd_addr_o),
        .gpr_we_o        (gpr_we_o),
        .mem_req_o       (mem_req_o),
        .mem_we_o        (mem_we_o),
        .mem_size_o      (mem_size_o),
        .branch_o        (branch_o),
        .jal_o           (jal_o),
        .jalr_o          (jalr_o),
        .illegal_instr_o (illegal_instr_o)
    );

    assign act = {pc_o, alu_op_o, a_sel_o, b_sel_o, imm_o, rs1_addr_o, rs2_addr_o, rd_addr_o,
                  gpr_we_o, mem_req_o, mem_we_o, mem_size_o, branch_o, jal_o, jalr_o, illegal_instr_o};

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    function automatic logic [BW-1:0] body(
        input logic [5:0] alu, input logic [1:0] a, input logic [2:0] b, input logic [31:0] imm,
        input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
        input logic gw, input logic mr, input logic mw, input logic [2:0] sz,
        input logic br, input logic jl, input logic jr, input logic il);
        return {alu, a, b, imm, rs1, rs2, rd, gw, mr, mw, sz, br, jl, jr, il};
    endfunction

    task automatic fill_table();
        tbl_instr[0]  = 32'hFFF10093; tbl_body[0]  = body(E_ADD, 0, 1, 32'hFFFF_FFFF, 2, 31, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        tbl_instr[1]  = 32'h402081B3; tbl_body[1]  = body(E_SUB, 0, 0, 32'h0, 1, 2, 3, 1, 0, 0, 0, 0, 0, 0, 0);
        tbl_instr[2]  = 32'h00208463; tbl_body[2]  = body(E_EQ,  0, 0, 32'h8, 1, 2, 8, 0, 0, 0, 0, 1, 0, 0, 0);
        tbl_instr[3]  = 32'h123452B7; tbl_body[3]  = body(E_ADD, 2, 1, 32'h1234_5000, 8, 3, 5, 1, 0, 0, 0, 0, 0, 0, 0);
        tbl_instr[4]  = 32'h00000000; tbl_body[4]  = body(E_ADD, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        tbl_instr[5]  = 32'h00000073; tbl_body[5]  = body(E_ADD, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        tbl_instr[6]  = 32'h00C0A303; tbl_body[6]  = body(E_ADD, 0, 1, 32'hC, 1, 12, 6, 1, 1, 0, 2, 0, 0, 0, 0);
        tbl_instr[7]  = 32'h0020A423; tbl_body[7]  = body(E_ADD, 0, 1, 32'h8, 1, 2, 8, 0, 1, 1, 2, 0, 0, 0, 0);
        tbl_instr[8]  = 32'h010000EF; tbl_body[8]  = body(E_ADD, 1, 2, 32'h10, 0, 16, 1, 1, 0, 0, 0, 0, 1, 0, 0);
        tbl_instr[9]  = 32'h0051A213; tbl_body[9]  = body(E_LTS, 0, 1, 32'h5, 3, 5, 4, 1, 0, 0, 0, 0, 0, 0, 0);
        tbl_instr[10] = 32'h202081B3; tbl_body[10] = body(E_ADD, 0, 0, 32'h0, 1, 2, 3, 0, 0, 0, 0, 0, 0, 0, 1);
        tbl_instr[11] = 32'h0020A463; tbl_body[11] = body(E_ADD, 0, 0, 32'h0, 1, 2, 8, 0, 0, 0, 0, 0, 0, 0, 1);
        tbl_instr[12] = 32'h00001397; tbl_body[12] = body(E_ADD, 1, 1, 32'h1000, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0, 0);
        tbl_instr[13] = 32'h40335293; tbl_body[13] = body(E_SRA, 0, 1, 32'h403, 6, 3, 5, 1, 0, 0, 0, 0, 0, 0, 0);
        tbl_instr[14] = 32'h004100E7; tbl_body[14] = body(E_ADD, 1, 2, 32'h4, 2, 4, 1, 1, 0, 0, 0, 0, 0, 1, 0);
        tbl_instr[15] = 32'h0000000F; tbl_body[15] = body(E_ADD, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (arstn_i && ex_valid_o && ex_ready_i) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_bundle got=%h expected=none", act);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                if (act !== e) begin
                    errors++;
                    $display("FAIL bundle got=%h expected=%h", act, e);
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic send(input int idx);
        bit accepted;
        accepted      = 1'b0;
        instr_i       = tbl_instr[idx];
        pc_i          = next_pc;
        instr_valid_i = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (instr_ready_o && !flush_i) begin
                exp_q.push_back({next_pc, tbl_body[idx]});
                accepted = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        instr_valid_i = 1'b0;
        next_pc       = next_pc + 32'd4;
        checks++;
        if (!accepted) begin
            errors++;
            $display("FAIL send_timeout idx=%0d got=not_accepted expected=accepted", idx);
        end
    endtask

    task automatic drain();
        for (int n = 0; n < 30 && exp_q.size() != 0; n++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d expected=0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        arstn_i = 1'b0; flush_i = 1'b0; instr_valid_i = 1'b0; ex_ready_i = 1'b1;
        instr_i = 32'h0; pc_i = 32'h0;
        repeat (3) @(negedge clk);
        checks++;
        if (ex_valid_o !== 1'b0 || pc_o !== RST_PC || alu_op_o !== E_ADD || instr_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset valid=%b pc=%h alu=%b rdy=%b expected 0 %h %b 1",
                     ex_valid_o, pc_o, alu_op_o, instr_ready_o, RST_PC, E_ADD);
        end
        checks++;
        if (act[BW-7-1:0] !== '0) begin
            errors++;
            $display("FAIL reset_fields got=%h expected=0", act[BW-7-1:0]);
        end
        arstn_i = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_addi();
        send(0);
        @(negedge clk);
        checks++;
        if (ex_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL addi_latency valid=%b expected=1", ex_valid_o);
        end
        drain();
    endtask

    task automatic test_stall();
        logic [31:0] sub_pc;
        ex_ready_i = 1'b0;
        sub_pc     = next_pc;
        send(1);
        fork
            send(2);
            begin
                for (int c = 0; c < 3; c++) begin
                    @(negedge clk);
                    checks++;
                    if (instr_ready_o !== 1'b0 || ex_valid_o !== 1'b1 || act !== {sub_pc, tbl_body[1]}) begin
                        errors++;
                        $display("FAIL stall_hold c=%0d rdy=%b valid=%b got=%h expected=%h",
                                 c, instr_ready_o, ex_valid_o, act, {sub_pc, tbl_body[1]});
                    end
                end
                @(posedge clk);
                #1;
                ex_ready_i = 1'b1;
                @(negedge clk);
                checks++;
                if (instr_ready_o !== 1'b1) begin
                    errors++;
                    $display("FAIL stall_release rdy=%b expected=1", instr_ready_o);
                end
            end
        join
        drain();
    endtask

    task automatic test_decode_table();
        for (int i = 2; i < 16; i++) send(i);
        drain();
    endtask

    task automatic test_back_to_back();
        int t0;
        ex_ready_i = 1'b1;
        t0 = cyc;
        for (int i = 0; i < 8; i++) send($urandom_range(0, 15));
        checks++;
        if (cyc - t0 != 8) begin
            errors++;
            $display("FAIL back_to_back cycles=%0d expected=8", cyc - t0);
        end
        drain();
        fork
            for (int i = 0; i < 12; i++) send($urandom_range(0, 15));
            begin
                repeat (40) begin
                    @(posedge clk);
                    #1;
                    ex_ready_i = 1'($urandom_range(0, 1));
                end
                ex_ready_i = 1'b1;
            end
        join
        ex_ready_i = 1'b1;
        drain();
    endtask

    task automatic test_flush();
        ex_ready_i = 1'b0;
        send(3);
        flush_i       = 1'b1;
        instr_valid_i = 1'b1;
        instr_i       = tbl_instr[0];
        pc_i          = 32'hDEAD_0000;
        @(negedge clk);
        checks++;
        if (ex_valid_o !== 1'b1 || instr_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_pre valid=%b rdy=%b expected 1 0", ex_valid_o, instr_ready_o);
        end
        @(posedge clk);
        #1;
        flush_i = 1'b0; instr_valid_i = 1'b0; ex_ready_i = 1'b1;
        void'(exp_q.pop_back());
        @(negedge clk);
        checks++;
        if (ex_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_held valid=%b expected=0", ex_valid_o);
        end
        @(posedge clk);
        #1;
        flush_i = 1'b1; instr_valid_i = 1'b1;
        @(negedge clk);
        checks++;
        if (instr_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL flush_ready rdy=%b expected=1", instr_ready_o);
        end
        @(posedge clk);
        #1;
        flush_i = 1'b0; instr_valid_i = 1'b0;
        @(negedge clk);
        checks++;
        if (ex_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_incoming valid=%b expected=0", ex_valid_o);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_stall();
        ex_ready_i = 1'b0;
        send(6);
        #3;
        arstn_i = 1'b0;
        #1;
        checks++;
        if (ex_valid_o !== 1'b0 || pc_o !== RST_PC || alu_op_o !== E_ADD || mem_req_o !== 1'b0 || rd_addr_o !== 5'd0) begin
            errors++;
            $display("FAIL reset_mid_stall valid=%b pc=%h alu=%b mreq=%b rd=%0d expected 0 %h %b 0 0",
                     ex_valid_o, pc_o, alu_op_o, mem_req_o, rd_addr_o, RST_PC, E_ADD);
        end
        void'(exp_q.pop_back());
        @(negedge clk);
        arstn_i    = 1'b1;
        ex_ready_i = 1'b1;
        @(posedge clk);
        #1;
        send(9);
        drain();
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        cyc     = 0;
        next_pc = 32'h0000_1000;
        fill_table();
        test_reset();
        test_addi();
        test_stall();
        test_decode_table();
        test_back_to_back();
        test_flush();
        test_reset_mid_stall();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/miriscv_decode_stage.md
Name: miriscv_decode_stage

Overview:
- Registered RV32I instruction decode stage for the miriscv core. It sits between fetch and the execute stage that holds the ALU.
- Consumes one fetched instruction per handshake and produces the ALU operator code (ALU_* from defines.v), operand selects, immediate, register addresses and control strobes.
- Holds one pipeline register with valid/ready handshakes on both sides, plus flush and illegal-instruction detection.

Parameters:
- RESET_PC, 32'h0000_0000, value loaded into pc_o on reset.

Ports:
- clk_i  input  1  clock; all state updates on its rising edge
- arstn_i  input  1  reset, asynchronous, active-low
- flush_i  input  1  discard held and incoming instruction
- instr_valid_i  input  1  fetch presents an instruction
- instr_ready_o  output  1  stage accepts an instruction this cycle
- instr_i  input  32  instruction word
- pc_i  input  32  PC of instr_i
- ex_valid_o  output  1  decoded bundle valid
- ex_ready_i  input  1  execute consumes the bundle
- pc_o  output  32  PC of held instruction
- alu_op_o  output  6  ALU_* operator code
- a_sel_o  output  2  operand A select: 0=rs1, 1=pc, 2=zero
- b_sel_o  output  3  operand B select: 0=rs2, 1=imm_o, 2=const 4
- imm_o  output  32  sign-extended immediate (I/S/B/U/J per opcode)
- rs1_addr_o, rs2_addr_o, rd_addr_o  output  5 each  register fields
- gpr_we_o  output  1  write rd
- mem_req_o  output  1  load/store
- mem_we_o  output  1  store
- mem_size_o  output  3  funct3 of load/store
- branch_o, jal_o, jalr_o  output  1 each  control-flow kind
- illegal_instr_o  output  1  held instruction is illegal

Behaviour:
- Reset (async, arstn_i=0): ex_valid_o=0, pc_o=RESET_PC, all other registered outputs 0. alu_op_o resets to ALU_ADD.
- instr_ready_o = !ex_valid_o || ex_ready_i (combinational). While flush_i=1, instr_ready_o is still driven the same way, but nothing is captured.
- Load: when instr_valid_i && instr_ready_o && !flush_i, the decode of instr_i/pc_i is registered and ex_valid_o=1 on the next cycle. Latency is exactly 1 cycle.
- Drain: if ex_ready_i=1 and nothing is loaded, ex_valid_o clears next cycle.
- Stall: if ex_valid_o && !ex_ready_i, all outputs hold stable and no instruction is accepted.
- Flush takes priority over load and stall: ex_valid_o=0 next cycle. Data outputs may hold; only valid is cleared.
- Back-to-back: with ex_ready_i=1 the stage sustains one instruction per cycle.
- OP (0110011): a_sel=0, b_sel=0, gpr_we=1. funct7=0100000 is legal only with funct3 000 (SUB) or 101 (SRA). Any other funct7 ≠ 0 is illegal.
- OP-IMM (0010011): b_sel=1, I-immediate. SLLI requires funct7=0. SRLI/SRAI are selected by funct7 0000000/0100000; other funct7 values are illegal.
- SLT/SLTU and SLTI/SLTIU map to ALU_LTS/ALU_LTU.
- LUI: a_sel=2, b_sel=1, ALU_ADD, imm={instr[31:12],12'b0}.
- AUIPC: a_sel=1, same immediate as LUI.
- JAL: a_sel=1, b_sel=2, ALU_ADD, jal_o=1, J-immediate, gpr_we=1.
- JALR: funct3 must be 000; same operand selects as JAL, jalr_o=1, I-immediate.
- BRANCH: a_sel=0, b_sel=0, branch_o=1, B-immediate, gpr_we=0. Operator by funct3: 000 EQ, 001 NE, 100 LTS, 101 GES, 110 LTU, 111 GEU; 010/011 are illegal.
- LOAD: funct3 ∈ {000,001,010,100,101}, ALU_ADD rs1+imm_I, mem_req=1, gpr_we=1.
- STORE: funct3 ∈ {000,001,010}, S-immediate, mem_req=1, mem_we=1.
- MISC-MEM (FENCE): decoded as a NOP, gpr_we=0.
- SYSTEM (ECALL/EBREAK/CSR) is unsupported and illegal.
- Illegal (also instr[1:0]≠11 or unknown opcode): illegal_instr_o=1, gpr_we=0, mem_req=0, mem_we=0, branch/jal/jalr=0, alu_op=ALU_ADD. ex_valid_o still asserts so execute can trap.
- Reset mid-stall: the bundle is dropped and ex_valid_o=0 immediately.

Decomposition:
- Extend defines.v with opcode constants (OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE, OPC_MISC_MEM, OPC_SYSTEM) and select encodings (OP_A_*, OP_B_*). ALU_* codes are reused unchanged.
- One sub-module: miriscv_decoder, the purely combinational instruction-to-bundle logic.
- miriscv_decode_stage adds the register, handshake and flush around it.

Test Plan:
- Reset, then instr 0xFFF10093 (addi x1,x2,-1), ex_ready_i=1 -> next cycle ex_valid_o=1, alu_op=ALU_ADD, b_sel=1, imm_o=0xFFFFFFFF, rs1=2, rd=1, gpr_we=1.
- 0x402081B3 (sub x3,x1,x2) while ex_ready_i=0 for 3 cycles -> outputs stable, instr_ready_o=0; on release, bundle consumed and next instr accepted same cycle.
- 0x00208463 (beq x1,x2,+8) -> alu_op=ALU_EQ, branch_o=1, imm_o=8, gpr_we=0.
- 0x123452B7 (lui x5,0x12345) -> a_sel=2, imm_o=0x12345000, rd=5.
- 0x00000000 and 0x00000073 -> illegal_instr_o=1, gpr_we=0, mem_req=0, ex_valid_o=1.
- flush_i asserted with instr_valid_i=1 and a held valid bundle -> ex_valid_o=0 next cycle, incoming instr discarded; arstn_i pulsed low mid-stall -> ex_valid_o=0 asynchronously.
